// File: rtl/instr_queue_if.sv
// Fetch-side bundle between the instruction queue, the reorder buffer,
// the instruction cache and the decoder.
interface instr_queue_if #(
  parameter int PcLength    = 31,
  parameter int InstrLength = 31
);
  logic                   is_ready_from_rob;
  logic                   is_exception_from_rob;
  logic [PcLength:0]      pc_from_rob;
  logic                   is_hit_from_ic;
  logic [PcLength:0]      pc_from_ic;
  logic [InstrLength:0]   instr_from_ic;
  logic                   is_fetch_to_ic;
  logic [PcLength:0]      pc_to_ic;
  logic                   is_empty_to_dc;
  logic [InstrLength:0]   instr_to_dc;
  logic [PcLength:0]      pc_to_dc;

  // Environment side: ROB/cache drive, cache/decoder observe
  modport master (
    output is_ready_from_rob, is_exception_from_rob, pc_from_rob,
    output is_hit_from_ic, pc_from_ic, instr_from_ic,
    input  is_fetch_to_ic, pc_to_ic,
    input  is_empty_to_dc, instr_to_dc, pc_to_dc
  );

  // Queue side
  modport slave (
    input  is_ready_from_rob, is_exception_from_rob, pc_from_rob,
    input  is_hit_from_ic, pc_from_ic, instr_from_ic,
    output is_fetch_to_ic, pc_to_ic,
    output is_empty_to_dc, instr_to_dc, pc_to_dc
  );
endinterface

// File: rtl/instr_queue.sv
// Instruction queue: issues sequential fetches to the I-cache, buffers the
// returned words in a circular FIFO and hands one per cycle to the decoder
// while the ROB has room. A ROB exception flushes everything and restarts
// fetch at the redirect PC.
module instr_queue #(
  parameter int QueueLength   = 16,
  parameter int PointerLength = 4,
  parameter int PcLength      = 31,
  parameter int InstrLength   = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  instr_queue_if.slave  bus
);

  localparam logic [PointerLength:0] FULL_COUNT = (PointerLength+1)'(QueueLength);
  localparam logic [PcLength:0]      PC_STEP    = (PcLength+1)'(4);

  logic [InstrLength:0]   instr_mem [QueueLength];
  logic [PcLength:0]      pc_mem    [QueueLength];

  logic [PointerLength-1:0] head;
  logic [PointerLength-1:0] tail;
  logic [PointerLength:0]   count;
  logic [PcLength:0]        fetch_pc;
  logic                     outstanding;

  logic                   is_fetch_q;
  logic [PcLength:0]      pc_to_ic_q;
  logic                   is_empty_q;
  logic [InstrLength:0]   instr_dc_q;
  logic [PcLength:0]      pc_dc_q;

  logic accept;
  logic issue;
  logic request;

  // Qualify the cache response, the decoder hand-off and a new fetch request
  always_comb begin
    accept  = bus.is_hit_from_ic && outstanding && (bus.pc_from_ic == fetch_pc);
    issue   = (count != '0) && bus.is_ready_from_rob;
    request = !outstanding && (count < FULL_COUNT);
  end

  // Pointers, occupancy, fetch tracking and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      fetch_pc    <= '0;
      outstanding <= 1'b0;
      is_fetch_q  <= 1'b0;
      pc_to_ic_q  <= '0;
      is_empty_q  <= 1'b1;
      instr_dc_q  <= '0;
      pc_dc_q     <= '0;
    end else if (rdy) begin
      if (bus.is_exception_from_rob) begin
        // Flush: a response landing this cycle is dropped, fetch restarts next cycle
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        fetch_pc    <= bus.pc_from_rob;
        outstanding <= 1'b0;
        is_empty_q  <= 1'b1;
        is_fetch_q  <= 1'b0;
      end else begin
        // Request and accept are mutually exclusive: one needs outstanding low, the other high
        is_fetch_q <= request;
        if (request) begin
          pc_to_ic_q  <= fetch_pc;
          outstanding <= 1'b1;
        end
        if (accept) begin
          tail        <= tail + 1'b1;
          fetch_pc    <= fetch_pc + PC_STEP;
          outstanding <= 1'b0;
        end

        if (issue) begin
          is_empty_q <= 1'b0;
          instr_dc_q <= instr_mem[head];
          pc_dc_q    <= pc_mem[head];
          head       <= head + 1'b1;
        end else begin
          is_empty_q <= 1'b1;
        end

        case ({accept, issue})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO storage: written at tail on an accepted response
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QueueLength; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (rdy && !bus.is_exception_from_rob && accept) begin
      instr_mem[tail] <= bus.instr_from_ic;
      pc_mem[tail]    <= fetch_pc;
    end
  end

  assign bus.is_fetch_to_ic = is_fetch_q;
  assign bus.pc_to_ic       = pc_to_ic_q;
  assign bus.is_empty_to_dc = is_empty_q;
  assign bus.instr_to_dc    = instr_dc_q;
  assign bus.pc_to_dc       = pc_dc_q;

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed PC sequences.
module tb_instr_queue;
  localparam int QL = 16;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  instr_queue_if bus();

  instr_queue dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Reference model state
  entry_t      mq[$];
  logic [31:0] m_fpc, m_pcic, m_instr, m_pcdc;
  logic        m_out, m_fetch, m_empty;

  int checks   = 0;
  int failures = 0;

  logic [31:0] issued[$];
  logic [31:0] fetched[$];
  bit          auto_cache;
  int          fetch_pulses;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: FIFO as an SV queue, outputs derived from the behavioural rules
  task automatic model_edge();
    if (rst) begin
      mq.delete();
      m_fpc = '0; m_out = 1'b0; m_fetch = 1'b0; m_pcic = '0;
      m_empty = 1'b1; m_instr = '0; m_pcdc = '0;
    end else if (rdy) begin
      if (bus.is_exception_from_rob) begin
        mq.delete();
        m_fpc = bus.pc_from_rob; m_out = 1'b0; m_empty = 1'b1; m_fetch = 1'b0;
      end else begin
        bit acc, pop, req;
        acc = bus.is_hit_from_ic && m_out && (bus.pc_from_ic == m_fpc);
        pop = (mq.size() > 0) && bus.is_ready_from_rob;
        req = !m_out && (mq.size() < QL);
        if (pop) begin
          entry_t e;
          e = mq.pop_front();
          m_empty = 1'b0; m_pcdc = e.pc; m_instr = e.instr;
        end else begin
          m_empty = 1'b1;
        end
        if (acc) begin
          mq.push_back({m_fpc, bus.instr_from_ic});
          m_fpc = m_fpc + 32'd4;
          m_out = 1'b0;
        end
        m_fetch = req;
        if (req) begin
          m_pcic = m_fpc;
          m_out  = 1'b1;
        end
      end
    end
  endtask

  // Cache answers a visible request in the same cycle it is seen
  task automatic drive_cache();
    if (auto_cache && bus.is_fetch_to_ic === 1'b1) begin
      bus.is_hit_from_ic = 1'b1;
      bus.pc_from_ic     = bus.pc_to_ic;
      bus.instr_from_ic  = bus.pc_to_ic ^ 32'hA5A5_0000;
    end else begin
      bus.is_hit_from_ic = 1'b0;
    end
  endtask

  // One clock: advance the model, then compare every output just after the edge
  task automatic step();
    bit live;
    live = (rdy === 1'b1) && (rst === 1'b0);
    model_edge();
    @(posedge clk);
    #1;
    chk1 ("is_fetch_to_ic", bus.is_fetch_to_ic, m_fetch);
    chk32("pc_to_ic",       bus.pc_to_ic,       m_pcic);
    chk1 ("is_empty_to_dc", bus.is_empty_to_dc, m_empty);
    chk32("instr_to_dc",    bus.instr_to_dc,    m_instr);
    chk32("pc_to_dc",       bus.pc_to_dc,       m_pcdc);
    if (live && bus.is_empty_to_dc === 1'b0) issued.push_back(bus.pc_to_dc);
    if (live && bus.is_fetch_to_ic === 1'b1) begin
      fetch_pulses++;
      fetched.push_back(bus.pc_to_ic);
    end
    drive_cache();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.is_exception_from_rob = 1'b0;
    bus.is_hit_from_ic = 1'b0;
    step();
    step();
    rst = 1'b0;
    issued.delete();
    fetched.delete();
  endtask

  task automatic wait_fetch(input logic [31:0] pc, input int budget, input string name);
    int n = 0;
    while (!(bus.is_fetch_to_ic === 1'b1 && bus.pc_to_ic === pc) && n < budget) begin
      step();
      n++;
    end
    chk1(name, (n < budget), 1'b1);
  endtask

  function automatic logic [31:0] at(input int i);
    if (i < issued.size()) return issued[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] fat(input int i);
    if (i < fetched.size()) return fetched[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    auto_cache = 1'b0;
    fetch_pulses = 0;
    bus.is_ready_from_rob     = 1'b1;
    bus.is_exception_from_rob = 1'b0;
    bus.pc_from_rob           = '0;
    bus.is_hit_from_ic        = 1'b0;
    bus.pc_from_ic            = '0;
    bus.instr_from_ic         = '0;

    // Reset state
    do_reset();
    chk1 ("reset empty",     bus.is_empty_to_dc, 1'b1);
    chk1 ("reset fetch",     bus.is_fetch_to_ic, 1'b0);
    chk32("reset pc_to_ic",  bus.pc_to_ic,       32'h0);

    // Streaming fetch and issue
    auto_cache = 1'b1;
    bus.is_ready_from_rob = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk32("stream fetch0", fat(0), 32'h0);
    chk32("stream fetch1", fat(1), 32'h4);
    chk32("stream fetch2", fat(2), 32'h8);
    chk32("stream issue0", at(0), 32'h0);
    chk32("stream issue1", at(1), 32'h4);
    chk32("stream issue2", at(2), 32'h8);

    // Backpressure until full, then drain
    do_reset();
    bus.is_ready_from_rob = 1'b0;
    for (int i = 0; i < 34; i++) step();
    fetch_pulses = 0;
    for (int i = 0; i < 6; i++) step();
    chk32("full model count", 32'(mq.size()), 32'd16);
    chk32("full no fetch",    32'(fetch_pulses), 32'd0);
    issued.delete();
    fetched.delete();
    bus.is_ready_from_rob = 1'b1;
    for (int i = 0; i < 20; i++) step();
    for (int i = 0; i < 16; i++) chk32($sformatf("drain issue%0d", i), at(i), 32'(4 * i));
    chk32("drain issue16", at(16), 32'd64);
    chk32("drain refetch", fat(0), 32'd64);

    // Exception with 5 buffered entries and a fetch to 0x20 outstanding
    do_reset();
    bus.is_ready_from_rob = 1'b0;
    wait_fetch(32'h20, 60, "exc reach 0x20");
    auto_cache = 1'b0;
    bus.is_hit_from_ic = 1'b0;
    bus.is_ready_from_rob = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk32("exc model count", 32'(mq.size()), 32'd5);
    issued.delete();
    fetched.delete();
    bus.is_exception_from_rob = 1'b1;
    bus.pc_from_rob           = 32'h0000_1000;
    bus.is_hit_from_ic        = 1'b1;
    bus.pc_from_ic            = 32'h20;
    bus.instr_from_ic         = 32'h1234_5678;
    step();
    bus.is_exception_from_rob = 1'b0;
    chk1("exc empty", bus.is_empty_to_dc, 1'b1);
    auto_cache = 1'b1;
    bus.is_hit_from_ic = 1'b1;
    bus.pc_from_ic     = 32'h20;
    step();
    for (int i = 0; i < 10; i++) step();
    chk32("exc refetch pc", fat(0), 32'h0000_1000);
    chk32("exc first issue", at(0), 32'h0000_1000);
    chk32("exc second issue", at(1), 32'h0000_1004);

    // rdy low for three cycles mid-stream
    do_reset();
    bus.is_ready_from_rob = 1'b1;
    for (int i = 0; i < 11; i++) step();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rdy = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk1("freeze issue count", (issued.size() >= 10), 1'b1);
    for (int i = 0; i < 10; i++) chk32($sformatf("freeze issue%0d", i), at(i), 32'(4 * i));

    // Wrap-around over 40 instructions
    do_reset();
    begin
      int n = 0;
      while (issued.size() < 40 && n < 200) begin
        step();
        n++;
      end
      chk1("wrap reached 40", (n < 200), 1'b1);
    end
    for (int i = 0; i < 40; i++) chk32($sformatf("wrap issue%0d", i), at(i), 32'(4 * i));

    // Reset while 7 entries are buffered and 0x1C is outstanding
    do_reset();
    bus.is_ready_from_rob = 1'b0;
    wait_fetch(32'h1C, 60, "rst reach 0x1C");
    chk32("rst model count", 32'(mq.size()), 32'd7);
    auto_cache = 1'b0;
    bus.is_hit_from_ic = 1'b1;
    bus.pc_from_ic     = 32'h1C;
    bus.instr_from_ic  = 32'h1C ^ 32'hA5A5_0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1 ("rst empty",    bus.is_empty_to_dc, 1'b1);
    chk1 ("rst fetch",    bus.is_fetch_to_ic, 1'b0);
    chk32("rst pc_to_ic", bus.pc_to_ic,       32'h0);
    chk32("rst pc_to_dc", bus.pc_to_dc,       32'h0);
    chk32("rst instr",    bus.instr_to_dc,    32'h0);
    issued.delete();
    fetched.delete();
    auto_cache = 1'b1;
    bus.is_hit_from_ic = 1'b0;
    bus.is_ready_from_rob = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk32("rst refetch pc", fat(0), 32'h0);
    chk32("rst first issue", at(0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Fetch-side instruction buffer, directly upstream of the decoder and the reorder buffer in the out-of-order core.
- Generates sequential fetch requests to the instruction cache and stores returned instructions in a circular FIFO.
- Hands one instruction per cycle to the decoder while the reorder buffer reports space.
- On a reorder-buffer exception (mispredict) it flushes all contents and restarts fetch at the corrected PC.

Parameters:
- QueueLength, 16, number of FIFO entries; power of two.
- PointerLength, 4, head/tail pointer width (log2 QueueLength).
- PcLength, 31, MSB index of PC fields (32-bit PC).
- InstrLength, 31, MSB index of instruction word (32-bit).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; when 0 all state holds.
- is_ready_from_rob  in  1  reorder buffer can accept a new entry this cycle.
- is_exception_from_rob  in  1  flush request; valid for one cycle.
- pc_from_rob  in  32  redirect target, valid with is_exception_from_rob.
- is_hit_from_ic  in  1  instruction cache returns a valid word this cycle.
- pc_from_ic  in  32  PC of the returned word.
- instr_from_ic  in  32  returned instruction word.
- is_fetch_to_ic  out  1  fetch request strobe (one-cycle pulse).
- pc_to_ic  out  32  address of the requested fetch.
- is_empty_to_dc  out  1  0 means instr_to_dc/pc_to_dc hold a valid instruction this cycle.
- instr_to_dc  out  32  issued instruction.
- pc_to_dc  out  32  PC of the issued instruction.

Behaviour:
- Reset (rst=1 at posedge) clears the following:
  - head=0, tail=0, count=0.
  - fetch_pc=0, outstanding=0.
  - is_fetch_to_ic=0, pc_to_ic=0.
  - is_empty_to_dc=1, instr_to_dc=0, pc_to_dc=0.
  - FIFO storage is cleared.
- Reset mid-operation discards any outstanding fetch.
- rdy=0: no register changes, including outputs.
- Priority per cycle: rst > !rdy > exception > normal operation.
- Exception:
  - head=tail=0, count=0.
  - fetch_pc <= pc_from_rob, outstanding <= 0.
  - is_empty_to_dc <= 1, is_fetch_to_ic <= 0.
  - Any cache response arriving in that cycle is dropped.
  - Fetch restarts at the next cycle.
- Fetch request:
  - Issued when outstanding=0 and count < QueueLength.
  - Registered outputs: is_fetch_to_ic <= 1, pc_to_ic <= fetch_pc, outstanding <= 1.
  - is_fetch_to_ic is high for exactly one cycle per request.
  - At most one request is outstanding.
- Fetch response:
  - Accepted only when is_hit_from_ic=1, outstanding=1 and pc_from_ic==fetch_pc.
  - On accept: write {instr, pc} at tail, tail <= tail+1 (wraps modulo QueueLength), fetch_pc <= fetch_pc+4, outstanding <= 0.
  - Non-matching responses are ignored (stale after a flush).
  - A new request may be issued no earlier than the cycle after an accept, giving a minimum of 2 cycles per fetched word.
- Issue:
  - If count>0 and is_ready_from_rob=1: is_empty_to_dc <= 0, instr_to_dc/pc_to_dc <= entry[head], head <= head+1 (wraps).
  - Otherwise is_empty_to_dc <= 1; instr_to_dc/pc_to_dc hold their last values.
  - Issue latency: an instruction accepted at cycle N appears on the outputs at N+2 at the earliest (stored at N+1, issued N+1 → visible N+2).
  - Each entry is presented for exactly one cycle; the consumer latches it whenever is_empty_to_dc=0.
- Count:
  - Push and pop in the same cycle leave count unchanged.
  - Push only: +1. Pop only: −1.
  - Full (count=QueueLength) blocks new requests.
  - An in-flight response can never overflow, because requests are only issued when count < QueueLength and at most one is outstanding.
  - Empty (count=0) blocks issue.
  - Push into empty and pop from empty never occur in the same cycle; a word written this cycle is not issuable until the next.
- Width rules: pointers wrap naturally at 2^PointerLength; fetch_pc+4 wraps at 2^32 without a flag.

Test Plan:
- Reset, then rdy=1, cache answers every request 1 cycle later with instr=pc^32'hA5A5_0000 and is_ready_from_rob=1 → pc_to_ic sequence 0,4,8,…; decoder receives pc_to_dc 0,4,8 in order, each with is_empty_to_dc=0 for one cycle.
- is_ready_from_rob=0 for 40 cycles with cache always hitting → count reaches 16 and no further is_fetch_to_ic pulses; on release, 16 consecutive issue cycles with pc 0..60, then fetch resumes at 64.
- Exception with pc_from_rob=32'h0000_1000 while 5 entries are buffered and a fetch to 0x20 is outstanding → is_empty_to_dc=1 next cycle; a late response with pc 0x20 is dropped; next is_fetch_to_ic has pc_to_ic=0x1000 and the first issued pc is 0x1000.
- rdy=0 for 3 cycles mid-stream → outputs and pointers frozen; sequence resumes without a gap or duplicate once rdy returns.
- Wrap-around: push/pop 40 instructions continuously → head/tail wrap twice, with no lost or duplicated PCs across index 15→0.
- rst asserted while count=7 and a fetch is outstanding → all outputs return to reset values next cycle; fetch restarts at pc 0.
